ysyx_ifu: RTL and testbench

Parametrised instruction fetch unit for the multi-cycle ysyx core, replacing the single-cycle in-top fetch. Keeps up to MAX_OUT word fetches in flight on a valid/ready memory request channel and buffers returned instructions, with their PCs and an error flag, in a DEPTH-entry prefetch queue. The queue drains to the IDU over a valid/ready handshake. A redirect from the EXU (jump/branch) flushes the queue and discards stale in-flight responses.

---
 rtl/ysyx_pkg.sv | 14 +
 rtl/ysyx_ifu_if.sv | 32 +++
 rtl/ysyx_sync_fifo.sv | 64 ++++++
 rtl/ysyx_ifu.sv | 95 +++++++++
 tb/tb_ysyx_ifu.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_pkg.sv
// rtl/ysyx_pkg.sv - shared constants and types for the ysyx fetch path
package ysyx_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // One prefetch-queue entry as seen by the IDU.
  typedef struct packed {
    logic                    err;
    logic [DEFAULT_XLEN-1:0] pc;
    logic [31:0]             data;
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_ifu_if.sv
// rtl/ysyx_ifu_if.sv - fetch request/response, redirect and IDU delivery bundle
interface ysyx_ifu_if #(
  parameter int XLEN = ysyx_pkg::DEFAULT_XLEN
);

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_err;

  // IFU side
  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc, inst_err,
    input  req_ready, rsp_valid, rsp_data, rsp_err, redirect, redirect_pc, inst_ready
  );

  // Memory / EXU / IDU side
  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc, inst_err,
    output req_ready, rsp_valid, rsp_data, rsp_err, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/ysyx_sync_fifo.sv
// rtl/ysyx_sync_fifo.sv - small synchronous FIFO with flush and occupancy count
module ysyx_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths (e.g. MAX_OUT=3) correct.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is cleared on reset so the head reads zero until first written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/ysyx_ifu.sv
// rtl/ysyx_ifu.sv - pipelined instruction fetch with prefetch queue and redirect flush
module ysyx_ifu
  import ysyx_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2
) (
  input logic        clk,
  input logic        rst,
  ysyx_ifu_if.master bus
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int QW = $clog2(DEPTH + 1);
  localparam int EW = 1 + XLEN + 32;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   live;      // occupancy of the PC queue == live requests
  logic [CW-1:0]   drop;
  logic [XLEN-1:0] pc_head;
  logic            pc_full;
  logic            pc_empty;
  logic [EW-1:0]   pf_head;
  logic [QW-1:0]   pf_count;
  logic            pf_full;
  logic            pf_empty;
  logic            req_fire;
  logic            rsp_consumed;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            inst_fire;

  // Credits: total in flight bounded by MAX_OUT, and every live request must
  // already own a prefetch slot so a response can never overflow the queue.
  assign bus.req_valid = rst && !bus.redirect && !pc_full && !pf_full
                      && ((int'(live) + int'(drop)) < MAX_OUT)
                      && ((int'(pf_count) + int'(live)) < DEPTH);
  assign bus.req_addr  = fetch_pc;
  assign req_fire      = bus.req_valid && bus.req_ready;

  // A response with nothing owed is a protocol error and is simply ignored.
  assign rsp_consumed = bus.rsp_valid && ((drop != '0) || !pc_empty);
  assign rsp_drop     = bus.rsp_valid && (drop != '0);
  assign rsp_keep     = bus.rsp_valid && (drop == '0) && !pc_empty && !bus.redirect;
  assign inst_fire    = !pf_empty && bus.inst_ready && !bus.redirect;

  assign bus.inst_valid = !pf_empty;
  assign bus.inst_err   = pf_head[EW-1];
  assign bus.inst_pc    = pf_head[32 +: XLEN];
  assign bus.inst       = pf_head[31:0];

  ysyx_sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_pc_q (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head      (pc_head),
    .flush     (bus.redirect),
    .count     (live),
    .full      (pc_full),
    .empty     (pc_empty)
  );

  ysyx_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_pf_q (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data ({bus.rsp_err, pc_head, bus.rsp_data}),
    .pop       (inst_fire),
    .head      (pf_head),
    .flush     (bus.redirect),
    .count     (pf_count),
    .full      (pf_full),
    .empty     (pf_empty)
  );

  // Fetch PC and stale-response accounting; on redirect every live request
  // becomes owed-but-discarded, less the one answered this very cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      drop     <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc & ~XLEN'(3);
      drop     <= drop + live - CW'(rsp_consumed);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (rsp_drop) drop     <= drop - CW'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_ifu.sv
// tb/tb_ysyx_ifu.sv - randomized self-checking bench for ysyx_ifu
module tb_ysyx_ifu;
  import ysyx_pkg::*;

  localparam int          XLEN    = 32;
  localparam int          DEPTH   = 4;
  localparam int          MAX_OUT = 2;
  localparam logic [31:0] RST_PC  = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_ifu_if #(.XLEN(XLEN)) b ();

  ysyx_ifu #(.XLEN(XLEN), .RESET_PC(RST_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t        mq[$];
  int           n_pass, n_total, cyc, lat, req_pct, inst_pct;
  logic [31:0]  err_addr, exp_issue, exp_deliver, exp_a, obs_addr;
  fetch_entry_t obs_e, exp_e;
  bit           obs_req, obs_inst, obs_rsp, obs_ivalid, obs_rvalid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock: drive inputs at negedge, sample combinational outputs, advance the
  // memory model and the sequential-PC expectation, then wait for the next negedge.
  task automatic step(input bit rd = 1'b0, input logic [31:0] rd_pc = 32'h0);
    b.redirect    = rd;
    b.redirect_pc = rd_pc;
    b.req_ready   = ($urandom_range(99) < req_pct);
    b.inst_ready  = ($urandom_range(99) < inst_pct);
    obs_rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    b.rsp_valid = obs_rsp;
    if (obs_rsp) begin
      b.rsp_data = mem_word(mq[0].addr);
      b.rsp_err  = (mq[0].addr == err_addr);
      void'(mq.pop_front());
    end else begin
      b.rsp_data = $urandom;
      b.rsp_err  = 1'($urandom_range(1));
    end
    #1;
    obs_rvalid = b.req_valid;
    obs_ivalid = b.inst_valid;
    obs_req    = b.req_valid && b.req_ready;
    obs_addr   = b.req_addr;
    obs_inst   = b.inst_valid && b.inst_ready && !rd;
    obs_e      = '{err: b.inst_err, pc: b.inst_pc, data: b.inst};
    if (obs_req) begin
      mq.push_back('{addr: b.req_addr, due: cyc + lat});
      exp_a     = exp_issue;
      exp_issue = exp_issue + 32'd4;
    end
    if (obs_inst) begin
      exp_e       = '{err: (exp_deliver == err_addr), pc: exp_deliver, data: mem_word(exp_deliver)};
      exp_deliver = exp_deliver + 32'd4;
    end
    if (rd) begin
      exp_issue   = rd_pc & ~32'd3;
      exp_deliver = exp_issue;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    b.redirect = 1'b0; b.redirect_pc = '0; b.req_ready = 1'b0;
    b.rsp_valid = 1'b0; b.rsp_data = '0; b.rsp_err = 1'b0; b.inst_ready = 1'b0;
    mq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    exp_issue = RST_PC;
    exp_deliver = RST_PC;
    #1;
  endtask

  task automatic test_reset();
    lat = 1; req_pct = 100; inst_pct = 100; err_addr = '1;
    do_reset();
    n_total++;
    if (b.req_valid !== 1'b1 || b.req_addr !== RST_PC)
      $display("FAIL reset_first_req valid=%b addr=%h want 1 %h", b.req_valid, b.req_addr, RST_PC);
    else n_pass++;
    repeat (5) step();
    rst = 1'b0;
    #1;
    n_total++;
    if ({b.req_valid, b.inst_valid, b.inst_err} !== 3'b000 || b.inst !== 32'h0 || b.inst_pc !== 32'h0)
      $display("FAIL reset_outputs rv=%b iv=%b ie=%b inst=%h pc=%h want all 0",
               b.req_valid, b.inst_valid, b.inst_err, b.inst, b.inst_pc);
    else n_pass++;
    do_reset();
    n_total++;
    if (b.req_valid !== 1'b1 || b.req_addr !== RST_PC)
      $display("FAIL reset_rerelease valid=%b addr=%h want 1 %h", b.req_valid, b.req_addr, RST_PC);
    else n_pass++;
  endtask

  task automatic test_stream();
    lat = 1; req_pct = 100; inst_pct = 100; err_addr = '1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      n_total++;
      if (obs_req !== 1'b1 || obs_addr !== exp_a)
        $display("FAIL stream_req cyc=%0d fire=%b addr=%h want 1 %h", i, obs_req, obs_addr, exp_a);
      else n_pass++;
      n_total++;
      if (i >= 2) begin
        if (obs_inst !== 1'b1 || obs_e !== exp_e)
          $display("FAIL stream_inst cyc=%0d fire=%b got=%h want=%h", i, obs_inst, obs_e, exp_e);
        else n_pass++;
      end else begin
        if (obs_ivalid !== 1'b0)
          $display("FAIL stream_fill cyc=%0d inst_valid=%b want 0", i, obs_ivalid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int  nreq;
    bit  seen;
    lat = 1; req_pct = 100; inst_pct = 0; err_addr = '1;
    do_reset();
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (obs_req) begin
        nreq++;
        n_total++;
        if (obs_addr !== exp_a) $display("FAIL bp_addr got=%h want=%h", obs_addr, exp_a);
        else n_pass++;
      end
    end
    n_total++;
    if (nreq != DEPTH) $display("FAIL bp_count got=%0d want=%0d", nreq, DEPTH);
    else n_pass++;
    n_total++;
    if (obs_rvalid !== 1'b0) $display("FAIL bp_stall req_valid=%b want 0", obs_rvalid);
    else n_pass++;
    inst_pct = 100;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (obs_inst) begin
        n_total++;
        if (obs_e !== exp_e) $display("FAIL bp_inst got=%h want=%h", obs_e, exp_e);
        else n_pass++;
      end
      if (obs_req) begin
        seen = 1'b1;
        n_total++;
        if (obs_addr !== 32'h8000_0010) $display("FAIL bp_resume got=%h want=80000010", obs_addr);
        else n_pass++;
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL bp_resume_timeout got=no request want=request");
    end
  endtask

  task automatic test_redirect_stale();
    bit seen;
    lat = 3; req_pct = 100; inst_pct = 100; err_addr = '1;
    do_reset();
    step();
    step();
    n_total++;
    if (mq.size() != 2) $display("FAIL stale_outstanding got=%0d want=2", mq.size());
    else n_pass++;
    step(1'b1, 32'h8000_0100);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (i == 0) begin
        n_total++;
        if (obs_ivalid !== 1'b0) $display("FAIL stale_inst_valid got=%b want=0", obs_ivalid);
        else n_pass++;
      end
      if (obs_inst) begin
        seen = 1'b1;
        n_total++;
        if (obs_e.pc !== 32'h8000_0100 || obs_e !== exp_e)
          $display("FAIL stale_first got=%h want=%h", obs_e, exp_e);
        else n_pass++;
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL stale_timeout got=no delivery want=delivery");
    end
  endtask

  task automatic test_redirect_collision();
    int ndel;
    lat = 1; req_pct = 100; inst_pct = 100; err_addr = '1;
    do_reset();
    repeat (6) step();
    step(1'b1, 32'h8000_0200);
    n_total++;
    if (obs_rsp !== 1'b1 || obs_ivalid !== 1'b1)
      $display("FAIL collide_setup rsp=%b inst_valid=%b want 1 1", obs_rsp, obs_ivalid);
    else n_pass++;
    step();
    n_total++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h8000_0200 || obs_ivalid !== 1'b0)
      $display("FAIL collide_next fire=%b addr=%h iv=%b want 1 80000200 0", obs_req, obs_addr, obs_ivalid);
    else n_pass++;
    ndel = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_inst) begin
        ndel++;
        n_total++;
        if (obs_e !== exp_e) $display("FAIL collide_inst got=%h want=%h", obs_e, exp_e);
        else n_pass++;
      end
    end
    n_total++;
    if (ndel < 3) $display("FAIL collide_count got=%0d want>=3", ndel);
    else n_pass++;
  endtask

  task automatic test_err();
    int ndel, nerr;
    lat = 1; req_pct = 100; inst_pct = 100; err_addr = 32'h8000_0008;
    do_reset();
    ndel = 0;
    nerr = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (obs_inst) begin
        ndel++;
        if (obs_e.err) nerr++;
        n_total++;
        if (obs_e !== exp_e) $display("FAIL err_entry got=%h want=%h", obs_e, exp_e);
        else n_pass++;
      end
    end
    n_total++;
    if (ndel != 12 || nerr != 1) $display("FAIL err_summary got=%0d/%0d want=12/1", ndel, nerr);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] pcs[$];
    lat = 1; req_pct = 100; inst_pct = 100; err_addr = '1;
    do_reset();
    repeat (4) step();
    step(1'b1, 32'hFFFF_FFFE);
    step();
    n_total++;
    if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_req0 fire=%b addr=%h want 1 fffffffc", obs_req, obs_addr);
    else n_pass++;
    step();
    n_total++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0000_0000)
      $display("FAIL wrap_req1 fire=%b addr=%h want 1 00000000", obs_req, obs_addr);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      step();
      if (obs_inst) pcs.push_back(obs_e.pc);
    end
    n_total++;
    if (pcs.size() < 2 || pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0000_0000)
      $display("FAIL wrap_deliver n=%0d first=%h want fffffffc then 0", pcs.size(),
               (pcs.size() > 0) ? pcs[0] : 32'hx);
    else n_pass++;
  endtask

  task automatic test_random();
    bit rd, prev_rd;
    lat = 2; req_pct = 80; inst_pct = 70; err_addr = RST_PC + 32'd12;
    do_reset();
    prev_rd = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) begin
        err_addr = RST_PC + 32'd4 * $urandom_range(0, 15);
        do_reset();
        prev_rd = 1'b0;
      end
      if (i % 250 == 0) begin
        lat      = $urandom_range(1, 4);
        req_pct  = $urandom_range(40, 100);
        inst_pct = $urandom_range(30, 100);
      end
      rd = ($urandom_range(99) < 4);
      step(rd, $urandom);
      if (obs_req) begin
        n_total++;
        if (obs_addr !== exp_a) $display("FAIL rnd_req i=%0d got=%h want=%h", i, obs_addr, exp_a);
        else n_pass++;
      end
      if (obs_inst) begin
        n_total++;
        if (obs_e !== exp_e) $display("FAIL rnd_inst i=%0d got=%h want=%h", i, obs_e, exp_e);
        else n_pass++;
      end
      if (prev_rd) begin
        n_total++;
        if (obs_ivalid !== 1'b0) $display("FAIL rnd_flush i=%0d inst_valid=%b want 0", i, obs_ivalid);
        else n_pass++;
      end
      n_total++;
      if (mq.size() > MAX_OUT) $display("FAIL rnd_outstanding i=%0d got=%0d max=%0d", i, mq.size(), MAX_OUT);
      else n_pass++;
      prev_rd = rd;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_collision();
    test_err();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
